// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Constants and types shared by the asynchronous FIFO and its read-side
//   packer.
//   - FIFO_DSIZE / FIFO_ASIZE : default data and address widths of the FIFO
//   - pk_state_e              : packer state (gathering bytes / word on output)
//   - cnt_width()             : bits needed to hold the values 0..n
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DSIZE = 8;
  localparam int FIFO_ASIZE = 4;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_OUT  = 1'b1
  } pk_state_e;

  // Width of a counter that must represent 0..n inclusive; never below 1 bit
  // so that a zero-valued parameter still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pk_idle_timer.sv
// ----------------------------------------------------------------------------
// pk_idle_timer
//   Saturating idle counter for the read-side packer. Counts edges on which
//   'run' is high, clears on 'clr', and saturates at TMO. TMO = 0 disables it.
//   Ports:
//     rclk    in  read clock
//     rrst_n  in  asynchronous active-low reset
//     clr     in  clear the count (takes priority over run)
//     run     in  advance the count on this edge
//     expired out this edge brings the count to TMO
// ----------------------------------------------------------------------------
module pk_idle_timer
  import fifo_pkg::*;
#(
  parameter int TMO = 16
) (
  input  logic rclk,
  input  logic rrst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int            TW   = cnt_width(TMO);
  localparam bit            EN   = (TMO != 0);
  localparam logic [TW-1:0] SAT  = TW'(TMO);
  localparam logic [TW-1:0] LAST = EN ? TW'(TMO - 1) : '0;

  logic [TW-1:0] idle_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      idle_q <= '0;
    end else if (clr) begin
      idle_q <= '0;
    end else if (EN && run && (idle_q != SAT)) begin
      idle_q <= idle_q + TW'(1);
    end
  end

  // Asserted on the edge that moves the count from TMO-1 to TMO, so the
  // consumer can act on that same edge rather than one cycle later.
  assign expired = EN && run && (idle_q >= LAST);

endmodule

// File: rtl/fifo_rd_packer.sv
// ----------------------------------------------------------------------------
// fifo_rd_packer
//   Read-side consumer of the 8-bit asynchronous FIFO (read clock domain).
//   Pops bytes from a first-word-fall-through FIFO port, packs PACK bytes
//   little-endian into one word and offers it on a valid/ready handshake.
//   Partial words leave on 'flush' or after TMO idle cycles.
//   Ports:
//     rclk, rrst_n  read clock, asynchronous active-low reset
//     rempty        FIFO empty flag
//     rdata         FIFO head byte (valid while rempty = 0)
//     rinc          FIFO pop strobe (combinational)
//     flush         emit the current partial word
//     out_ready     downstream accept
//     out_valid     packed word valid
//     out_data      packed word, first byte in the lowest lane
//     out_cnt       number of valid bytes in out_data
// ----------------------------------------------------------------------------
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int PACK  = 4,
  parameter int TMO   = 16
) (
  input  logic                        rclk,
  input  logic                        rrst_n,
  input  logic                        rempty,
  input  logic [DSIZE-1:0]            rdata,
  output logic                        rinc,
  input  logic                        flush,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DSIZE*PACK-1:0]       out_data,
  output logic [cnt_width(PACK)-1:0]  out_cnt
);

  localparam int CW = cnt_width(PACK);

  pk_state_e             state, state_next;
  logic [CW-1:0]         cnt;
  logic [DSIZE*PACK-1:0] lanes;

  logic pop;
  logic accept;
  logic tmo_hit;
  logic idle_run;
  logic idle_clr;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= PK_FILL;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    accept     = 1'b0;
    case (state)
      PK_FILL: begin
        // Gating with rrst_n keeps the FIFO untouched while reset is held.
        pop = rrst_n && !rempty;
        // A flush or pop on this edge counts the popped byte, so the word
        // that leaves always includes it.
        if ((pop && (cnt == CW'(PACK - 1))) ||
            (flush && (pop || (cnt != '0))) ||
            (tmo_hit && (cnt != '0))) begin
          state_next = PK_OUT;
        end
      end
      PK_OUT: begin
        accept = out_ready;
        if (accept) begin
          state_next = PK_FILL;
        end
      end
    endcase
  end

  // ----------------------------------------------------- byte counter/lanes
  // NOTE: the lane register is reset as well as the control flops, because
  // out_data is required to read 0 out of reset and after a discarded word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt   <= '0;
      lanes <= '0;
    end else if (accept) begin
      cnt   <= '0;
      lanes <= '0;
    end else if (pop) begin
      cnt <= cnt + CW'(1);
      for (int i = 0; i < PACK; i++) begin
        if (cnt == CW'(i)) begin
          lanes[i*DSIZE +: DSIZE] <= rdata;
        end
      end
    end
  end

  // --------------------------------------------------------- idle timeout
  assign idle_run = (state == PK_FILL) && (cnt != '0) && !pop;
  assign idle_clr = pop || accept;

  pk_idle_timer #(
    .TMO (TMO)
  ) u_idle_timer (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .clr     (idle_clr),
    .run     (idle_run),
    .expired (tmo_hit)
  );

  // --------------------------------------------------------------- outputs
  assign rinc      = pop;
  assign out_valid = (state == PK_OUT);
  assign out_data  = lanes;
  assign out_cnt   = cnt;

endmodule
